// File: rtl/discrete_log_search_pkg.sv
// Shared DH constants and search FSM encoding.
// Also used by the modular-powering block.
package discrete_log_search_pkg;

   localparam int DH_N = 8;
   localparam int DH_P = 89;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      INIT   = 2'd1,
      SEARCH = 2'd2
   } state_t;

endpackage

// File: rtl/discrete_log_search_mod_mult.sv
// Combinational (a*b) mod P over a 2N-bit product.
// Operands are expected already reduced below P.
module discrete_log_search_mod_mult #(
   parameter int N = 8,
   parameter int P = 89
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] y
);

   localparam logic [2*N-1:0] PW = (2*N)'(P);

   logic [2*N-1:0] prod;
   logic [2*N-1:0] rem;

   always_comb begin
      prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
      rem  = prod % PW;
      y    = rem[N-1:0];
   end

endmodule

// File: rtl/discrete_log_search.sv
// Brute-force discrete log: smallest x with g^x mod P == y,
// one candidate exponent per enabled clock.
module discrete_log_search
   import discrete_log_search_pkg::*;
#(
   parameter int N = DH_N,
   parameter int P = DH_P
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic         start,
   input  logic [N-1:0] base,
   input  logic [N-1:0] target,
   output logic [N-1:0] res,
   output logic         found,
   output logic         rdy
);

   localparam logic [N:0]   PR  = (N+1)'(P);
   localparam logic [N-1:0] XMX = N'(P - 2);

   state_t       state;
   logic [N-1:0] acc;
   logic [N-1:0] x;
   logic [N-1:0] base_reg;
   logic [N-1:0] target_reg;
   logic [N-1:0] acc_next;
   logic [N:0]   base_red;
   logic [N:0]   target_red;

   always_comb begin
      base_red   = {1'b0, base} % PR;
      target_red = {1'b0, target} % PR;
   end

   discrete_log_search_mod_mult #(
      .N (N),
      .P (P)
   ) u_mod_mult (
      .a (acc),
      .b (base_reg),
      .y (acc_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         res        <= '0;
         found      <= 1'b0;
         rdy        <= 1'b0;
         acc        <= '0;
         x          <= '0;
         base_reg   <= '0;
         target_reg <= '0;
      end else if (ena) begin
         rdy <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start)
                  state <= INIT;
            end
            INIT: begin
               base_reg   <= base_red[N-1:0];
               target_reg <= target_red[N-1:0];
               acc        <= N'(1);
               x          <= '0;
               state      <= SEARCH;
            end
            SEARCH: begin
               if (acc == target_reg) begin
                  res   <= x;
                  found <= 1'b1;
                  rdy   <= 1'b1;
                  state <= IDLE;
               end else if (x == XMX) begin
                  // Range exhausted: report failure with res cleared.
                  res   <= '0;
                  found <= 1'b0;
                  rdy   <= 1'b1;
                  state <= IDLE;
               end else begin
                  acc <= acc_next;
                  x   <= x + N'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_discrete_log_search.sv
// Scoreboard bench for discrete_log_search on P=89.
// Latency counted in clock cycles from the start edge.
module tb_discrete_log_search;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic       start;
   logic [7:0] base;
   logic [7:0] target;
   logic [7:0] res;
   logic       found;
   logic       rdy;

   always #5 clk = ~clk;

   discrete_log_search dut (
      .clk    (clk),
      .rst    (rst),
      .ena    (ena),
      .start  (start),
      .base   (base),
      .target (target),
      .res    (res),
      .found  (found),
      .rdy    (rdy)
   );

   typedef struct {
      logic [7:0] res;
      logic       found;
      int         lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;

   logic [7:0] o_res;
   logic       o_found;
   logic       o_after;
   int         o_lat;
   bit         o_to;

   function automatic int powmod(int g, int e);
      int r = 1;
      int b = g % 89;
      while (e > 0) begin
         if (e[0]) r = (r * b) % 89;
         b = (b * b) % 89;
         e = e >> 1;
      end
      return r;
   endfunction

   function automatic exp_t model(int g, int t);
      exp_t e;
      e.res = 8'd0;
      e.found = 1'b0;
      e.lat = 90;
      for (int i = 87; i >= 0; i--)
         if (powmod(g, i) == t % 89) begin
            e.res = 8'(i);
            e.found = 1'b1;
            e.lat = 3 + i;
         end
      return e;
   endfunction

   function automatic exp_t mk(int r, bit f, int l);
      exp_t e;
      e.res = 8'(r);
      e.found = f;
      e.lat = l;
      return e;
   endfunction

   task automatic launch(input logic [7:0] b,
                         input logic [7:0] t,
                         input exp_t e);
      @(negedge clk);
      base = b;
      target = t;
      start = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic collect(input int k0);
      int k = k0;
      o_to = 1'b1;
      while (k < 200) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (rdy) begin
            o_to = 1'b0;
            break;
         end
      end
      o_res = res;
      o_found = found;
      o_lat = k + 1;
      @(negedge clk);
      o_after = rdy;
   endtask

   task automatic test_reset();
      checks++;
      if ({res, found, rdy} !== 10'd0)
         $display("FAIL reset_outputs got %h want 000",
                  {res, found, rdy});
      else passes++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({res, found, rdy} !== 10'd0)
         $display("FAIL idle_outputs got %h want 000",
                  {res, found, rdy});
      else passes++;
   endtask

   task automatic run_case(input string nm,
                           input logic [7:0] b,
                           input logic [7:0] t,
                           input exp_t e);
      exp_t x;
      launch(b, t, e);
      collect(0);
      x = sb.pop_front();
      checks++;
      if (o_to) $display("FAIL %s timeout", nm);
      else passes++;
      checks++;
      if (o_res !== x.res)
         $display("FAIL %s res got %0d want %0d", nm, o_res, x.res);
      else passes++;
      checks++;
      if (o_found !== x.found)
         $display("FAIL %s found got %0b want %0b", nm, o_found, x.found);
      else passes++;
      checks++;
      if (o_lat !== x.lat)
         $display("FAIL %s latency got %0d want %0d", nm, o_lat, x.lat);
      else passes++;
      checks++;
      if (o_after !== 1'b0)
         $display("FAIL %s rdy_width got %0b want 0", nm, o_after);
      else passes++;
   endtask

   task automatic test_not_found();
      run_case("nf_base1", 8'd1, 8'd5, mk(0, 0, 90));
      run_case("nf_t0", 8'd3, 8'd0, mk(0, 0, 90));
      run_case("nf_base0", 8'd0, 8'd7, mk(0, 0, 90));
   endtask

   task automatic test_found();
      run_case("f_3_2", 8'd3, 8'd2, mk(16, 1, 19));
      run_case("f_3_1", 8'd3, 8'd1, mk(0, 1, 3));
      run_case("f_3_81", 8'd3, 8'd81, mk(4, 1, 7));
      run_case("f_reduce", 8'd92, 8'd98, mk(2, 1, 5));
      run_case("f_base0_t0", 8'd0, 8'd0, mk(1, 1, 4));
      run_case("f_base1_t1", 8'd1, 8'd1, mk(0, 1, 3));
   endtask

   task automatic test_enable_hold();
      exp_t x;
      int   k = 0;
      launch(8'd3, 8'd2, mk(16, 1, 24));
      repeat (4) begin
         @(posedge clk);
         k++;
      end
      @(negedge clk);
      ena = 1'b0;
      repeat (5) begin
         @(posedge clk);
         k++;
      end
      @(negedge clk);
      ena = 1'b1;
      base = 8'd3;
      target = 8'd1;
      start = 1'b1;
      @(posedge clk);
      k++;
      @(negedge clk);
      start = 1'b0;
      collect(k);
      x = sb.pop_front();
      checks++;
      if (o_to) $display("FAIL ena_hold timeout");
      else passes++;
      checks++;
      if (o_res !== x.res)
         $display("FAIL ena_hold res got %0d want %0d", o_res, x.res);
      else passes++;
      checks++;
      if (o_lat !== x.lat)
         $display("FAIL ena_hold latency got %0d want %0d", o_lat, x.lat);
      else passes++;
   endtask

   task automatic test_reset_mid();
      launch(8'd3, 8'd2, mk(16, 1, 19));
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      void'(sb.pop_back());
      checks++;
      if ({res, found, rdy} !== 10'd0)
         $display("FAIL reset_mid got %h want 000", {res, found, rdy});
      else passes++;
      @(negedge clk);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      checks++;
      if ({res, found, rdy} !== 10'd0)
         $display("FAIL reset_mid_idle got %h want 000",
                  {res, found, rdy});
      else passes++;
      run_case("after_rst", 8'd3, 8'd81, mk(4, 1, 7));
   endtask

   task automatic test_back_to_back();
      logic [7:0] b;
      logic [7:0] t;
      for (int i = 0; i < 4; i++) begin
         b = 8'($urandom_range(2, 255));
         t = 8'($urandom_range(0, 255));
         run_case($sformatf("b2b_%0d_%0d", b, t), b, t, model(b, t));
      end
   endtask

   initial begin
      rst = 1'b1;
      ena = 1'b1;
      start = 1'b0;
      base = 8'd0;
      target = 8'd0;
      repeat (2) @(negedge clk);
      test_reset();
      test_not_found();
      test_found();
      test_enable_hold();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
